// File: rtl/alu_seq.sv
// alu_seq: sequences one request through an external ALU and returns a response.
// Ports: I_clk/I_reset (async, active-high); req (I_req_valid/O_req_ready,
// I_op/I_a/I_b/I_cond); ALU (O_alu_en/O_alu_op/O_alu_s1/O_alu_s2,
// I_alu_busy/I_alu_data/I_alu_lt/I_alu_ltu/I_alu_eq); rsp (O_rsp_valid/I_rsp_ready,
// O_rsp_data/O_rsp_taken/O_rsp_err). Optional macro: ALU_SEQ_TIMEOUT_EN.
module alu_seq (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_req_valid,
  output logic        O_req_ready,
  input  logic [3:0]  I_op,
  input  logic [31:0] I_a,
  input  logic [31:0] I_b,
  input  logic [2:0]  I_cond,
  output logic        O_alu_en,
  output logic [3:0]  O_alu_op,
  output logic [31:0] O_alu_s1,
  output logic [31:0] O_alu_s2,
  input  logic        I_alu_busy,
  input  logic [31:0] I_alu_data,
  input  logic        I_alu_lt,
  input  logic        I_alu_ltu,
  input  logic        I_alu_eq,
  output logic        O_rsp_valid,
  input  logic        I_rsp_ready,
  output logic [31:0] O_rsp_data,
  output logic        O_rsp_taken,
  output logic        O_rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  cond_q;
  logic [31:0] data_q;
  logic        lt_q;
  logic        ltu_q;
  logic        eq_q;
  logic        accept;
  logic        capture;
  logic        timeout;
  logic        err;

  function automatic logic cond_taken(
    input logic [2:0] c,
    input logic       lt,
    input logic       ltu,
    input logic       eq
  );
    case (c)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

`ifdef ALU_SEQ_TIMEOUT_EN
  logic [5:0] tmo_q;
  logic       err_q;

  assign timeout = (state_q == WAIT) && (tmo_q == 6'd40);
  assign err     = err_q;

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == ISSUE)
        tmo_q <= '0;
      else if (state_q == WAIT && I_alu_busy && !timeout)
        tmo_q <= tmo_q + 6'd1;
      if (capture)
        err_q <= 1'b0;
      else if (timeout)
        err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    O_req_ready = 1'b0;
    O_alu_en    = 1'b0;
    O_rsp_valid = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    unique case (state_q)
      IDLE: begin
        O_req_ready = !I_reset;
        accept      = I_req_valid;
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        O_alu_en = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        // enable follows busy so multi-cycle shifts keep running
        if (timeout) begin
          state_d = RESP;
        end else begin
          O_alu_en = I_alu_busy;
          if (!I_alu_busy) begin
            capture = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        O_rsp_valid = 1'b1;
        if (I_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cond_q  <= '0;
      data_q  <= '0;
      lt_q    <= 1'b0;
      ltu_q   <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= I_op;
        a_q    <= I_a;
        b_q    <= I_b;
        cond_q <= I_cond;
      end
      if (capture) begin
        data_q <= I_alu_data;
        lt_q   <= I_alu_lt;
        ltu_q  <= I_alu_ltu;
        eq_q   <= I_alu_eq;
      end else if (timeout) begin
        data_q <= '0;
        lt_q   <= 1'b0;
        ltu_q  <= 1'b0;
        eq_q   <= 1'b0;
      end
    end
  end

  assign O_alu_op    = op_q;
  assign O_alu_s1    = a_q;
  assign O_alu_s2    = b_q;
  assign O_rsp_data  = data_q;
  // error masks taken: a timed-out op never reports a branch
  assign O_rsp_taken = cond_taken(cond_q, lt_q, ltu_q, eq_q) & !err;
  assign O_rsp_err   = err;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: random + directed bench for alu_seq with a mock multi-cycle ALU.
// Expected data/taken/latency come from plain-arithmetic reference functions.
module tb_alu_seq;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SLL = 4'd2;
  localparam logic [3:0] OP_SRL = 4'd3;
  localparam logic [3:0] OP_SRA = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;

  logic        I_clk;
  logic        I_reset;
  logic        I_req_valid;
  logic        O_req_ready;
  logic [3:0]  I_op;
  logic [31:0] I_a;
  logic [31:0] I_b;
  logic [2:0]  I_cond;
  logic        O_alu_en;
  logic [3:0]  O_alu_op;
  logic [31:0] O_alu_s1;
  logic [31:0] O_alu_s2;
  logic        I_alu_busy;
  logic [31:0] I_alu_data;
  logic        I_alu_lt;
  logic        I_alu_ltu;
  logic        I_alu_eq;
  logic        O_rsp_valid;
  logic        I_rsp_ready;
  logic [31:0] O_rsp_data;
  logic        O_rsp_taken;
  logic        O_rsp_err;

  int checks = 0;
  int errors = 0;

  alu_seq dut (
    .I_clk      (I_clk),
    .I_reset    (I_reset),
    .I_req_valid(I_req_valid),
    .O_req_ready(O_req_ready),
    .I_op       (I_op),
    .I_a        (I_a),
    .I_b        (I_b),
    .I_cond     (I_cond),
    .O_alu_en   (O_alu_en),
    .O_alu_op   (O_alu_op),
    .O_alu_s1   (O_alu_s1),
    .O_alu_s2   (O_alu_s2),
    .I_alu_busy (I_alu_busy),
    .I_alu_data (I_alu_data),
    .I_alu_lt   (I_alu_lt),
    .I_alu_ltu  (I_alu_ltu),
    .I_alu_eq   (I_alu_eq),
    .O_rsp_valid(O_rsp_valid),
    .I_rsp_ready(I_rsp_ready),
    .O_rsp_data (O_rsp_data),
    .O_rsp_taken(O_rsp_taken),
    .O_rsp_err  (O_rsp_err)
  );

  initial begin
    I_clk = 1'b0;
    forever #5 I_clk = ~I_clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_shift(input logic [3:0] op);
    return op == OP_SLL || op == OP_SRL || op == OP_SRA;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $signed(a) >>> b[4:0];
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] c,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    case (c)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // mock ALU: results registered on the enable edge; a shift by n
  // stays busy for n+1 cycles after that edge
  logic       stub_busy;
  logic [4:0] stub_cnt;
  logic       force_busy;

  assign I_alu_busy = stub_busy | force_busy;

  always @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      stub_busy  <= 1'b0;
      stub_cnt   <= '0;
      I_alu_data <= '0;
      I_alu_lt   <= 1'b0;
      I_alu_ltu  <= 1'b0;
      I_alu_eq   <= 1'b0;
    end else if (!stub_busy) begin
      if (O_alu_en) begin
        I_alu_data <= ref_alu(O_alu_op, O_alu_s1, O_alu_s2);
        I_alu_lt   <= $signed(O_alu_s1) < $signed(O_alu_s2);
        I_alu_ltu  <= O_alu_s1 < O_alu_s2;
        I_alu_eq   <= O_alu_s1 == O_alu_s2;
        if (is_shift(O_alu_op)) begin
          stub_busy <= 1'b1;
          stub_cnt  <= O_alu_s2[4:0];
        end
      end
    end else if (stub_cnt == 5'd0) begin
      stub_busy <= 1'b0;
    end else begin
      stub_cnt <= stub_cnt - 5'd1;
    end
  end

  task automatic run_op(input logic [3:0]  op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [2:0]  cond,
                        input int          stall);
    int          k;
    int          en_n;
    int          lat_exp;
    int          en_exp;
    logic [31:0] d0;
    logic        t0;
    lat_exp = is_shift(op) ? 4 + int'(b[4:0]) : 3;
    en_exp  = is_shift(op) ? 2 + int'(b[4:0]) : 1;
    @(negedge I_clk);
    chk("req_ready_idle", 32'(O_req_ready), 32'd1);
    I_req_valid = 1'b1;
    I_op   = op;
    I_a    = a;
    I_b    = b;
    I_cond = cond;
    @(negedge I_clk);
    // keep valid up while busy when stalling; scramble inputs
    I_req_valid = (stall > 0);
    I_op   = 4'($urandom);
    I_a    = $urandom;
    I_b    = $urandom;
    I_cond = 3'($urandom);
    chk("latched_op", 32'(O_alu_op), 32'(op));
    chk("latched_s1", O_alu_s1, a);
    chk("latched_s2", O_alu_s2, b);
    k    = 1;
    en_n = 0;
    while (!O_rsp_valid && k < 200) begin
      if (O_alu_en) en_n++;
      if (O_req_ready) chk("ready_while_busy", 32'(O_req_ready), 32'd0);
      @(negedge I_clk);
      k++;
    end
    chk("latency", 32'(k), 32'(lat_exp));
    chk("en_cycles", 32'(en_n), 32'(en_exp));
    chk("rsp_data", O_rsp_data, ref_alu(op, a, b));
    chk("rsp_taken", 32'(O_rsp_taken), 32'(ref_taken(cond, a, b)));
    chk("rsp_err", 32'(O_rsp_err), 32'd0);
    d0 = O_rsp_data;
    t0 = O_rsp_taken;
    repeat (stall) begin
      @(negedge I_clk);
      chk("stall_valid", 32'(O_rsp_valid), 32'd1);
      chk("stall_data", O_rsp_data, d0);
      chk("stall_taken", 32'(O_rsp_taken), 32'(t0));
      chk("stall_ready", 32'(O_req_ready), 32'd0);
      chk("stall_en", 32'(O_alu_en), 32'd0);
    end
    I_rsp_ready = 1'b1;
    I_req_valid = 1'b0;
    @(negedge I_clk);
    I_rsp_ready = 1'b0;
    chk("valid_drop", 32'(O_rsp_valid), 32'd0);
    chk("back_idle", 32'(O_req_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          k;
    I_reset     = 1'b1;
    I_req_valid = 1'b0;
    I_op        = '0;
    I_a         = '0;
    I_b         = '0;
    I_cond      = '0;
    I_rsp_ready = 1'b0;
    force_busy  = 1'b0;
    @(negedge I_clk);
    chk("rst_req_ready", 32'(O_req_ready), 32'd0);
    chk("rst_alu_en", 32'(O_alu_en), 32'd0);
    chk("rst_rsp_valid", 32'(O_rsp_valid), 32'd0);
    chk("rst_rsp_data", O_rsp_data, 32'd0);
    chk("rst_rsp_taken", 32'(O_rsp_taken), 32'd0);
    chk("rst_rsp_err", 32'(O_rsp_err), 32'd0);
    chk("rst_alu_s1", O_alu_s1, 32'd0);
    @(negedge I_clk);
    I_reset = 1'b0;
    #1;
    chk("rel_req_ready", 32'(O_req_ready), 32'd1);

    run_op(OP_ADD, 32'd5, 32'd7, 3'b000, 0);
    run_op(OP_SLL, 32'd1, 32'd5, 3'b000, 0);
    run_op(OP_SUB, 32'hFFFF_FFFF, 32'd1, 3'b100, 0);
    run_op(OP_SUB, 32'hFFFF_FFFF, 32'd1, 3'b110, 0);
    run_op(OP_ADD, 32'd100, 32'd23, 3'b001, 10);
    run_op(OP_SRA, 32'h8000_0000, 32'd0, 3'b010, 1);
    run_op(OP_SRL, 32'hFFFF_FFFF, 32'd31, 3'b011, 0);

    // reset in the middle of a long shift
    @(negedge I_clk);
    I_req_valid = 1'b1;
    I_op   = OP_SRA;
    I_a    = 32'h8765_4321;
    I_b    = 32'd20;
    I_cond = 3'b000;
    @(negedge I_clk);
    I_req_valid = 1'b0;
    repeat (4) @(negedge I_clk);
    chk("mid_wait_en", 32'(O_alu_en), 32'd1);
    I_reset = 1'b1;
    #1;
    chk("mid_rst_en", 32'(O_alu_en), 32'd0);
    chk("mid_rst_valid", 32'(O_rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(O_req_ready), 32'd0);
    @(negedge I_clk);
    I_reset = 1'b0;
    #1;
    chk("mid_rel_ready", 32'(O_req_ready), 32'd1);
    seen = 1'b0;
    repeat (30) begin
      @(negedge I_clk);
      if (O_rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_rst", 32'(seen), 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_op(op, a, b, 3'($urandom), $urandom_range(0, 3));
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    force_busy = 1'b1;
    @(negedge I_clk);
    I_req_valid = 1'b1;
    I_op   = OP_ADD;
    I_a    = 32'd3;
    I_b    = 32'd4;
    I_cond = 3'b001;
    @(negedge I_clk);
    I_req_valid = 1'b0;
    k = 1;
    while (!O_rsp_valid && k < 200) begin
      @(negedge I_clk);
      k++;
    end
    chk("tmo_valid", 32'(O_rsp_valid), 32'd1);
    chk("tmo_en", 32'(O_alu_en), 32'd0);
    chk("tmo_err", 32'(O_rsp_err), 32'd1);
    chk("tmo_data", O_rsp_data, 32'd0);
    chk("tmo_taken", 32'(O_rsp_taken), 32'd0);
    force_busy  = 1'b0;
    I_rsp_ready = 1'b1;
    @(negedge I_clk);
    I_rsp_ready = 1'b0;
    chk("tmo_idle", 32'(O_req_ready), 32'd1);
    run_op(OP_ADD, 32'd5, 32'd7, 3'b000, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have port I_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port I_reset, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL have port I_req_valid, input, 1, operation request valid.
REQ-004 SHALL have port O_req_ready, output, 1, request accepted when valid and ready are both 1 at a clock edge.
REQ-005 SHALL have ports I_op (input, 4, ALU opcode), I_a (input, 32, operand 1), I_b (input, 32, operand 2), I_cond (input, 3, branch condition in RISC-V funct3 encoding).
REQ-006 SHALL have ports O_alu_en (output, 1), O_alu_op (output, 4), O_alu_s1 (output, 32), O_alu_s2 (output, 32): drive the ALU enable, opcode and operands.
REQ-007 SHALL have ports I_alu_busy (input, 1), I_alu_data (input, 32), I_alu_lt, I_alu_ltu, I_alu_eq (inputs, 1 each): ALU busy, result and registered compare flags.
REQ-008 SHALL have ports O_rsp_valid (output, 1), I_rsp_ready (input, 1), O_rsp_data (output, 32), O_rsp_taken (output, 1), O_rsp_err (output, 1): response channel.

Function
REQ-009 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-010 IDLE: O_req_ready=1; on I_req_valid, latch I_op/I_a/I_b/I_cond into internal registers -> ISSUE. O_req_ready=0 in every other state.
REQ-011 O_alu_op/O_alu_s1/O_alu_s2 SHALL be driven from the latched registers only, stable from ISSUE through WAIT.
REQ-012 ISSUE: O_alu_en=1 for exactly one cycle -> WAIT.
REQ-013 WAIT: O_alu_en = I_alu_busy (combinational, holds enable through multi-cycle shifts); when I_alu_busy=0, capture I_alu_data, I_alu_lt, I_alu_ltu, I_alu_eq -> RESP.
REQ-014 O_rsp_taken SHALL be computed from captured flags: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu, 010/011 -> 0.
REQ-015 RESP: O_rsp_valid=1, O_rsp_data/O_rsp_taken/O_rsp_err held stable until I_rsp_ready=1 at an edge -> IDLE.
REQ-016 Latency, accept at edge T: single-cycle ops, O_rsp_valid first high in cycle T+3; shift by n (0..31), cycle T+4+n.
REQ-017 O_alu_en SHALL be 0 in IDLE and RESP; no new request SHALL be accepted before the previous response is consumed.
REQ-018 Response stalled indefinitely (I_rsp_ready=0) SHALL hold all response outputs unchanged.

Reset
REQ-019 On I_reset=1, immediately: state IDLE, O_req_ready=0 while asserted, O_alu_en=0, O_rsp_valid=0, O_rsp_data=0, O_rsp_taken=0, O_rsp_err=0, latched registers 0.
REQ-020 Reset asserted mid-operation (ISSUE/WAIT/RESP) SHALL abandon the operation with no response emitted; O_req_ready=1 in the first cycle after release.

Configuration
REQ-021 Macro ALU_SEQ_TIMEOUT_EN defined: 6-bit counter cleared on ISSUE, incremented each WAIT cycle with I_alu_busy=1; at count 40 SHALL force O_alu_en=0, go RESP with O_rsp_data=0, O_rsp_taken=0, O_rsp_err=1.
REQ-022 Macro ALU_SEQ_TIMEOUT_EN undefined: no counter, O_rsp_err tied 0, WAIT waits indefinitely.

Verification
REQ-023 ADD, I_a=5, I_b=7, accept at T, I_rsp_ready=1 -> O_rsp_valid at T+3, O_rsp_data=12, O_rsp_err=0.
REQ-024 SLL, I_a=1, I_b=5, accept at T -> O_alu_en high T+1..T+7, O_rsp_valid at T+9, O_rsp_data=32.
REQ-025 SUB, I_a=0xFFFFFFFF, I_b=1, I_cond=100 -> O_rsp_taken=1; same with I_cond=110 -> O_rsp_taken=0.
REQ-026 ADD result in RESP, I_rsp_ready=0 for 10 cycles with I_req_valid=1 -> outputs stable, O_req_ready=0; ready=1 -> IDLE, next request accepted.
REQ-027 I_reset pulsed during WAIT of SRA by 20 -> O_alu_en=0 and O_rsp_valid=0 immediately, no response, O_req_ready=1 after release.
REQ-028 With ALU_SEQ_TIMEOUT_EN, I_alu_busy forced 1 -> O_rsp_valid with O_rsp_err=1, O_rsp_data=0 after 40 WAIT cycles.
